cpu_core_mc: RTL and testbench

- Parametrised successor to the single-cycle 8-bit CPU top.
- Width and register count are parameters; adds a rotate instruction.
- Adds load/store instructions over a data-memory port with a BUSYWAIT stall handshake.
- Instruction fetch stays external: INSTRUCTION is driven combinationally from PC by the instruction memory. The core owns the PC, register file, ALU/shifter, branch logic and the memory-request FSM.

---
 rtl/cpu_core_mc_if.sv | 22 ++
 rtl/cpu_core_mc.sv | 146 ++++++++++++++
 tb/tb_cpu_core_mc.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_core_mc_if.sv
// Data-memory port of cpu_core_mc: registered request side from the core,
// READDATA/BUSYWAIT returned by the memory.
interface cpu_core_mc_if #(
    parameter int DATA_W = 8
);
    logic              READ;
    logic              WRITE;
    logic [DATA_W-1:0] ADDRESS;
    logic [DATA_W-1:0] WRITEDATA;
    logic [DATA_W-1:0] READDATA;
    logic              BUSYWAIT;

    modport master (
        output READ, WRITE, ADDRESS, WRITEDATA,
        input  READDATA, BUSYWAIT
    );

    modport slave (
        input  READ, WRITE, ADDRESS, WRITEDATA,
        output READDATA, BUSYWAIT
    );
endinterface

// File: rtl/cpu_core_mc.sv
// Parametrised single-issue CPU core: register file, ALU/shifter, branch unit
// and a two-state EXEC/MEM FSM that stalls the PC on data-memory accesses.
module cpu_core_mc #(
    parameter int DATA_W = 8,
    parameter int NREG   = 8,
    parameter int PC_W   = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    output logic [PC_W-1:0]  PC,
    input  logic [31:0]      INSTRUCTION,
    cpu_core_mc_if.master    dmem
);
    localparam int IDX_W = (NREG > 1) ? $clog2(NREG) : 1;
    localparam logic [7:0] DW8 = 8'(DATA_W);

    typedef enum logic {EXEC, MEM} state_t;

    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic              read_q, read_d, write_q, write_d;
    logic [DATA_W-1:0] addr_q, addr_d, wdata_q, wdata_d;
    logic [DATA_W-1:0] regs_q [NREG];

    logic              rf_we;
    logic [IDX_W-1:0]  rf_waddr;
    logic [DATA_W-1:0] rf_wdata;

    logic [7:0]        opcode, imm8;
    logic [IDX_W-1:0]  rd_idx, rs1_idx, rs2_idx;
    logic [DATA_W-1:0] op_a, op_b, imm;
    logic [DATA_W-1:0] sll_res, srl_res, sra_res, ror_res;
    logic [2*DATA_W-1:0] rot_dbl;
    logic [7:0]        rot_amt;
    logic              shamt_big;
    logic [PC_W-1:0]   pc_plus4, br_target;
    logic              is_mem, mem_reg_addr;
    logic              unused_src1_hi;

    assign opcode  = INSTRUCTION[31:24];
    assign rd_idx  = INSTRUCTION[16 +: IDX_W];
    assign rs1_idx = INSTRUCTION[8 +: IDX_W];
    assign rs2_idx = INSTRUCTION[0 +: IDX_W];
    assign imm8    = INSTRUCTION[7:0];
    assign imm     = DATA_W'(imm8);
    assign unused_src1_hi = ^INSTRUCTION[15:8];

    assign op_a = regs_q[rs1_idx];
    assign op_b = regs_q[rs2_idx];

    // Shift amounts at or beyond the width saturate instead of wrapping.
    assign shamt_big = (imm8 >= DW8);
    assign sll_res   = shamt_big ? '0 : (op_a << imm8);
    assign srl_res   = shamt_big ? '0 : (op_a >> imm8);
    assign sra_res   = shamt_big ? {DATA_W{op_a[DATA_W-1]}} : DATA_W'($signed(op_a) >>> imm8);
    assign rot_amt   = imm8 % DW8;
    assign rot_dbl   = {op_a, op_a} >> rot_amt;
    assign ror_res   = rot_dbl[DATA_W-1:0];

    assign pc_plus4  = pc_q + PC_W'(4);
    assign br_target = pc_plus4 + {{(PC_W-10){INSTRUCTION[23]}}, INSTRUCTION[23:16], 2'b00};

    assign is_mem       = (opcode == 8'h0E) || (opcode == 8'h0F) ||
                          (opcode == 8'h10) || (opcode == 8'h11);
    assign mem_reg_addr = (opcode == 8'h0E) || (opcode == 8'h10);

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        read_d   = read_q;
        write_d  = write_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rf_we    = 1'b0;
        rf_waddr = rd_idx;
        rf_wdata = '0;
        case (state_q)
            EXEC: begin
                pc_d = pc_plus4;
                if (is_mem) begin
                    addr_d  = mem_reg_addr ? op_b : imm;
                    wdata_d = op_a;
                    read_d  = (opcode == 8'h0E) || (opcode == 8'h0F);
                    write_d = (opcode == 8'h10) || (opcode == 8'h11);
                    pc_d    = pc_q;
                    state_d = MEM;
                end else begin
                    case (opcode)
                        8'h00: begin rf_we = 1'b1; rf_wdata = imm;         end
                        8'h01: begin rf_we = 1'b1; rf_wdata = op_b;        end
                        8'h02: begin rf_we = 1'b1; rf_wdata = op_a + op_b; end
                        8'h03: begin rf_we = 1'b1; rf_wdata = op_a - op_b; end
                        8'h04: begin rf_we = 1'b1; rf_wdata = op_a & op_b; end
                        8'h05: begin rf_we = 1'b1; rf_wdata = op_a | op_b; end
                        8'h06: pc_d = br_target;
                        8'h07: if (op_a == op_b) pc_d = br_target;
                        8'h08: if (op_a != op_b) pc_d = br_target;
                        8'h09: begin rf_we = 1'b1; rf_wdata = sll_res; end
                        8'h0A: begin rf_we = 1'b1; rf_wdata = srl_res; end
                        8'h0B: begin rf_we = 1'b1; rf_wdata = sra_res; end
                        8'h0C: begin rf_we = 1'b1; rf_wdata = ror_res; end
                        default: ;
                    endcase
                end
            end
            MEM: begin
                // INSTRUCTION is held stable by the fetch side, so dest is still valid here.
                if (!dmem.BUSYWAIT) begin
                    rf_we    = read_q;
                    rf_wdata = dmem.READDATA;
                    read_d   = 1'b0;
                    write_d  = 1'b0;
                    pc_d     = pc_plus4;
                    state_d  = EXEC;
                end
            end
            default: state_d = EXEC;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= EXEC;
            pc_q    <= '0;
            read_q  <= 1'b0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            read_q  <= read_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            if (rf_we) regs_q[rf_waddr] <= rf_wdata;
        end
    end

    assign PC             = pc_q;
    assign dmem.READ      = read_q;
    assign dmem.WRITE     = write_q;
    assign dmem.ADDRESS   = addr_q;
    assign dmem.WRITEDATA = wdata_q;
endmodule

// File: tb/tb_cpu_core_mc.sv
// Drives an 8-bit/8-reg core and a 16-bit/16-reg core with the same instruction
// stream and checks both against an instruction-level reference model.
module tb_cpu_core_mc;
    logic        CLK = 1'b0;
    logic        RESET;
    logic [31:0] INSTRUCTION;
    logic        busy;
    logic [31:0] rdata;
    logic [31:0] pc8, pc16;
    int n_cmp = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    cpu_core_mc_if #(.DATA_W(8))  bus8 ();
    cpu_core_mc_if #(.DATA_W(16)) bus16 ();
    assign bus8.BUSYWAIT  = busy;
    assign bus8.READDATA  = rdata[7:0];
    assign bus16.BUSYWAIT = busy;
    assign bus16.READDATA = rdata[15:0];

    cpu_core_mc #(.DATA_W(8), .NREG(8), .PC_W(32)) dut8 (
        .CLK(CLK), .RESET(RESET), .PC(pc8), .INSTRUCTION(INSTRUCTION), .dmem(bus8));
    cpu_core_mc #(.DATA_W(16), .NREG(16), .PC_W(32)) dut16 (
        .CLK(CLK), .RESET(RESET), .PC(pc16), .INSTRUCTION(INSTRUCTION), .dmem(bus16));

    logic [31:0] o_pc [2], o_addr [2], o_wd [2];
    logic        o_rd [2], o_wr [2];
    always_comb begin
        o_pc[0] = pc8;   o_addr[0] = {24'd0, bus8.ADDRESS};  o_wd[0] = {24'd0, bus8.WRITEDATA};
        o_pc[1] = pc16;  o_addr[1] = {16'd0, bus16.ADDRESS}; o_wd[1] = {16'd0, bus16.WRITEDATA};
        o_rd[0] = bus8.READ;  o_wr[0] = bus8.WRITE;
        o_rd[1] = bus16.READ; o_wr[1] = bus16.WRITE;
    end

    // Reference model: architectural state per configuration
    logic [31:0] mreg [2][256];
    logic [31:0] mpc  [2];
    int DWC [2] = '{8, 16};
    int NRC [2] = '{8, 16};

    function automatic logic [31:0] msk(int c);
        return (c == 0) ? 32'h0000_00FF : 32'h0000_FFFF;
    endfunction

    function automatic logic [31:0] ins(logic [7:0] op, logic [7:0] d, logic [7:0] s1, logic [7:0] s2);
        return {op, d, s1, s2};
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            mpc[c] = 32'd0;
            for (int i = 0; i < 256; i++) mreg[c][i] = 32'd0;
        end
    endtask

    function automatic logic [31:0] shift_ref(logic [7:0] op, logic [31:0] a, int sh, int w, logic [31:0] m);
        logic [31:0] r;
        logic        sgn;
        sgn = a[w-1];
        case (op)
            8'h09: r = (sh >= w) ? 32'd0 : ((a << sh) & m);
            8'h0A: r = (sh >= w) ? 32'd0 : (a >> sh);
            8'h0B: begin
                if (sh >= w) r = sgn ? m : 32'd0;
                else begin
                    r = a >> sh;
                    if (sgn) r = r | (m & ~(m >> sh));
                end
            end
            default: begin
                sh = sh % w;
                r = (sh == 0) ? a : (((a >> sh) | (a << (w - sh))) & m);
            end
        endcase
        return r;
    endfunction

    task automatic model_step(input logic [31:0] i, input logic [31:0] rd);
        logic [7:0]  op;
        logic [31:0] a, b, v, m;
        logic        wr, tk;
        int d, s1, s2;
        op = i[31:24];
        for (int c = 0; c < 2; c++) begin
            m  = msk(c);
            d  = int'(i[23:16]) % NRC[c];
            s1 = int'(i[15:8]) % NRC[c];
            s2 = int'(i[7:0]) % NRC[c];
            a  = mreg[c][s1];
            b  = mreg[c][s2];
            wr = 1'b1; tk = 1'b0; v = 32'd0;
            case (op)
                8'h00: v = {24'd0, i[7:0]};
                8'h01: v = b;
                8'h02: v = (a + b) & m;
                8'h03: v = (a - b) & m;
                8'h04: v = a & b;
                8'h05: v = a | b;
                8'h06: begin wr = 1'b0; tk = 1'b1; end
                8'h07: begin wr = 1'b0; tk = (a == b); end
                8'h08: begin wr = 1'b0; tk = (a != b); end
                8'h09, 8'h0A, 8'h0B, 8'h0C: v = shift_ref(op, a, int'(i[7:0]), DWC[c], m);
                8'h0E, 8'h0F: v = rd & m;
                default: wr = 1'b0;
            endcase
            if (wr) mreg[c][d] = v;
            mpc[c] = mpc[c] + 32'd4 + (tk ? {{22{i[23]}}, i[23:16], 2'b00} : 32'd0);
        end
    endtask

    // Issue one instruction; memory ops stall for nbusy BUSYWAIT cycles.
    task automatic exec(input logic [31:0] i, input int nbusy, input logic [31:0] rd);
        logic [7:0]  op;
        logic        ld, st;
        logic [31:0] ea, ewd;
        op = i[31:24];
        ld = (op == 8'h0E) || (op == 8'h0F);
        st = (op == 8'h10) || (op == 8'h11);
        INSTRUCTION = i;
        rdata = rd;
        busy = (ld || st) ? (nbusy > 0) : 1'($urandom_range(0, 1));
        for (int c = 0; c < 2; c++) begin
            n_cmp++;
            if (o_pc[c] !== mpc[c]) begin
                n_err++; $display("FAIL pc[dut%0d] ins=%h got %h exp %h", c, i, o_pc[c], mpc[c]);
            end
            n_cmp++;
            if ((o_rd[c] | o_wr[c]) !== 1'b0) begin
                n_err++; $display("FAIL idle_req[dut%0d] got rd=%b wr=%b exp 0", c, o_rd[c], o_wr[c]);
            end
        end
        @(posedge CLK); #1;
        if (ld || st) begin
            for (int k = 0; k <= nbusy; k++) begin
                for (int c = 0; c < 2; c++) begin
                    ea  = ((op == 8'h0E) || (op == 8'h10)) ? mreg[c][int'(i[7:0]) % NRC[c]]
                                                           : {24'd0, i[7:0]};
                    ea  = ea & msk(c);
                    ewd = mreg[c][int'(i[15:8]) % NRC[c]];
                    n_cmp++;
                    if (o_rd[c] !== ld || o_wr[c] !== st) begin
                        n_err++; $display("FAIL mem_req[dut%0d] cyc%0d got rd=%b wr=%b exp rd=%b wr=%b",
                                          c, k, o_rd[c], o_wr[c], ld, st);
                    end
                    n_cmp++;
                    if (o_addr[c] !== ea) begin
                        n_err++; $display("FAIL mem_addr[dut%0d] cyc%0d got %h exp %h", c, k, o_addr[c], ea);
                    end
                    n_cmp++;
                    if (o_wd[c] !== ewd) begin
                        n_err++; $display("FAIL mem_wdata[dut%0d] cyc%0d got %h exp %h", c, k, o_wd[c], ewd);
                    end
                    n_cmp++;
                    if (o_pc[c] !== mpc[c]) begin
                        n_err++; $display("FAIL pc_hold[dut%0d] cyc%0d got %h exp %h", c, k, o_pc[c], mpc[c]);
                    end
                end
                if (k == nbusy) busy = 1'b0;
                @(posedge CLK); #1;
            end
            for (int c = 0; c < 2; c++) begin
                n_cmp++;
                if ((o_rd[c] | o_wr[c]) !== 1'b0) begin
                    n_err++; $display("FAIL mem_release[dut%0d] got rd=%b wr=%b exp 0", c, o_rd[c], o_wr[c]);
                end
            end
        end
        model_step(i, rd);
        busy = 1'b0;
    endtask

    task automatic do_reset();
        RESET = 1'b0;
        @(posedge CLK); #1;
        RESET = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        INSTRUCTION = 32'd0; busy = 1'b0; rdata = 32'd0; RESET = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        for (int c = 0; c < 2; c++) begin
            n_cmp++;
            if (o_pc[c] !== 32'd0 || o_rd[c] !== 1'b0 || o_wr[c] !== 1'b0 ||
                o_addr[c] !== 32'd0 || o_wd[c] !== 32'd0) begin
                n_err++; $display("FAIL reset[dut%0d] got pc=%h rd=%b wr=%b addr=%h wd=%h exp all 0",
                                  c, o_pc[c], o_rd[c], o_wr[c], o_addr[c], o_wd[c]);
            end
        end
        RESET = 1'b1;
        model_reset();
    endtask

    task automatic test_alu();
        exec(ins(8'h00, 1, 0, 8'h05), 0, 0);
        exec(ins(8'h00, 2, 0, 8'h03), 0, 0);
        exec(ins(8'h03, 3, 1, 2), 0, 0);
        n_cmp++;
        if (o_pc[0] !== 32'h0C) begin
            n_err++; $display("FAIL alu_pc got %h exp 0000000c", o_pc[0]);
        end
        exec(ins(8'h11, 0, 3, 8'h40), 0, 0);
        n_cmp++;
        if (o_wd[0] !== 32'h02) begin
            n_err++; $display("FAIL sub_result got %h exp 00000002", o_wd[0]);
        end
    endtask

    task automatic test_shift();
        logic [31:0] exp8 [4] = '{32'hC0, 32'h40, 32'hC0, 32'h00};
        logic [7:0]  sop  [4] = '{8'h0B, 8'h0A, 8'h0C, 8'h09};
        logic [7:0]  samt [4] = '{8'd1, 8'd1, 8'd9, 8'd8};
        exec(ins(8'h00, 1, 0, 8'h81), 0, 0);
        for (int k = 0; k < 4; k++) begin
            exec(ins(sop[k], 4, 1, samt[k]), 0, 0);
            exec(ins(8'h11, 0, 4, 8'h00), 0, 0);
            n_cmp++;
            if (o_wd[0] !== exp8[k]) begin
                n_err++; $display("FAIL shift_op%h got %h exp %h", sop[k], o_wd[0], exp8[k]);
            end
        end
    endtask

    task automatic test_branch();
        do_reset();
        exec(ins(8'h00, 1, 0, 8'h11), 0, 0);
        repeat (3) exec(32'hFF00_0000, 0, 0);
        exec(ins(8'h07, 8'hFE, 1, 1), 0, 0);
        n_cmp++;
        if (o_pc[0] !== 32'h0C) begin
            n_err++; $display("FAIL beq_taken got %h exp 0000000c", o_pc[0]);
        end
        exec(ins(8'h08, 8'hFE, 1, 1), 0, 0);
        n_cmp++;
        if (o_pc[1] !== 32'h10) begin
            n_err++; $display("FAIL bne_untaken got %h exp 00000010", o_pc[1]);
        end
        do_reset();
        exec(ins(8'h06, 8'h7F, 0, 0), 0, 0);
        n_cmp++;
        if (o_pc[0] !== 32'h200) begin
            n_err++; $display("FAIL jump got %h exp 00000200", o_pc[0]);
        end
    endtask

    task automatic test_store_stall();
        exec(ins(8'h00, 1, 0, 8'h5A), 0, 0);
        exec(ins(8'h11, 0, 1, 8'h20), 3, 0);
        n_cmp++;
        if (o_addr[0] !== 32'h20 || o_wd[0] !== 32'h5A) begin
            n_err++; $display("FAIL store_bus got addr=%h wd=%h exp addr=20 wd=5a", o_addr[0], o_wd[0]);
        end
    endtask

    task automatic test_load();
        exec(ins(8'h00, 2, 0, 8'h20), 0, 0);
        exec(ins(8'h0E, 5, 0, 2), 0, 32'h0000_55AA);
        exec(ins(8'h11, 0, 5, 8'h00), 0, 0);
        n_cmp++;
        if (o_wd[0] !== 32'hAA || o_wd[1] !== 32'h55AA) begin
            n_err++; $display("FAIL load_value got %h/%h exp 000000aa/000055aa", o_wd[0], o_wd[1]);
        end
    endtask

    task automatic test_reset_mid_mem();
        exec(ins(8'h00, 7, 0, 8'h33), 0, 0);
        INSTRUCTION = ins(8'h0F, 5, 0, 8'h30);
        busy = 1'b1;
        @(posedge CLK); #2;
        RESET = 1'b0;
        #1;
        for (int c = 0; c < 2; c++) begin
            n_cmp++;
            if (o_pc[c] !== 32'd0 || o_rd[c] !== 1'b0 || o_wr[c] !== 1'b0 || o_addr[c] !== 32'd0) begin
                n_err++; $display("FAIL async_reset[dut%0d] got pc=%h rd=%b wr=%b addr=%h exp 0",
                                  c, o_pc[c], o_rd[c], o_wr[c], o_addr[c]);
            end
        end
        @(posedge CLK); #1;
        RESET = 1'b1;
        busy = 1'b0;
        model_reset();
        exec(ins(8'h11, 0, 5, 8'h00), 0, 0);
        n_cmp++;
        if (o_wd[0] !== 32'd0 || o_wd[1] !== 32'd0) begin
            n_err++; $display("FAIL abort_no_write got %h/%h exp 0", o_wd[0], o_wd[1]);
        end
    endtask

    task automatic test_wide_sra();
        exec(ins(8'h00, 1, 0, 8'h80), 0, 0);
        exec(ins(8'h09, 1, 1, 8'd8), 0, 0);
        exec(ins(8'h00, 6, 0, 8'h01), 0, 0);
        exec(ins(8'h05, 1, 1, 6), 0, 0);
        exec(ins(8'h0B, 4, 1, 8'd1), 0, 0);
        exec(ins(8'h11, 0, 4, 8'h00), 0, 0);
        n_cmp++;
        if (o_wd[1] !== 32'hC000) begin
            n_err++; $display("FAIL sra16 got %h exp 0000c000", o_wd[1]);
        end
    endtask

    task automatic test_random();
        logic [7:0] ops [20] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09,
                                 8'h0A, 8'h0B, 8'h0C, 8'h0E, 8'h0F, 8'h10, 8'h11, 8'h0D, 8'h12, 8'hFF};
        logic [7:0] imm;
        for (int n = 0; n < 200; n++) begin
            imm = $urandom_range(0, 1) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 18));
            exec(ins(ops[$urandom_range(0, 19)], 8'($urandom_range(0, 255)),
                     8'($urandom_range(0, 255)), imm),
                 $urandom_range(0, 3), $urandom);
        end
        for (int r = 0; r < 16; r++) exec(ins(8'h11, 0, 8'(r), 8'h00), 0, 0);
    endtask

    initial begin
        test_reset();
        test_alu();
        test_shift();
        test_branch();
        test_store_stall();
        test_load();
        test_reset_mid_mem();
        test_wide_sra();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
